// File: rtl/afpm_pkg.sv
// Shared types and constants for the logarithmic FP multiplier sequencer.
// Holds the sequencer state enum, pin/data widths and the FP16 quiet-NaN code.
package afpm_pkg;

    localparam int BYTE_W = 8;
    localparam int DATA_W = 16;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_HI,
        S_START,
        S_WAIT,
        S_OUT_LO,
        S_OUT_HI
    } state_e;

endpackage

// File: rtl/afpm_wdog.sv
// Loadable down-counter watchdog for the multiplier wait phase.
// Ports: clk, rst_n (async low); load reloads CNT_MAX; en counts down;
// expire pulses in the last counting cycle (count == 1 while en).
module afpm_wdog #(
    parameter int CNT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(CNT_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(CNT_MAX);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == CW'(1));

endmodule

// File: rtl/afpm_op_sequencer.sv
// Byte-wide front end for the 16-bit logarithmic FP multiplier core.
// Ports: clk, rst_n (async low), ena (freeze when low); byte_a/byte_b/
// byte_valid operand bytes (low byte first); clr clears sticky ovr;
// mul_a/mul_b/mul_start/mul_done/mul_result to the core; out_byte/
// out_valid/out_last/out_ready result bytes (low first); busy, ovr,
// err_timeout status. Macro AFPM_SEQ_TIMEOUT_EN adds a wait watchdog
// that substitutes qNaN when the core never signals done.
module afpm_op_sequencer #(
    parameter int DATA_W      = 16,
    parameter int BYTE_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [BYTE_W-1:0] byte_a,
    input  logic [BYTE_W-1:0] byte_b,
    input  logic              byte_valid,
    input  logic              clr,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_result,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovr,
    output logic              err_timeout
);

    import afpm_pkg::*;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              ovr_q, ovr_d;
    logic              accepting;
    logic              tmo;

    assign accepting = (state_q == S_IDLE) || (state_q == S_LOAD_HI);

`ifdef AFPM_SEQ_TIMEOUT_EN
    logic wd_expire;

    afpm_wdog #(
        .CNT_MAX(TIMEOUT_CYC)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ena && state_q == S_START),
        .en    (ena && state_q == S_WAIT),
        .expire(wd_expire)
    );

    // A done arriving in the expiry cycle still wins over the watchdog.
    assign tmo = wd_expire && !mul_done;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        ovr_d     = ovr_q;
        mul_start = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_byte  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (ena && byte_valid) begin
                    a_d[BYTE_W-1:0] = byte_a;
                    b_d[BYTE_W-1:0] = byte_b;
                    state_d = S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                if (ena && byte_valid) begin
                    a_d[DATA_W-1:BYTE_W] = byte_a;
                    b_d[DATA_W-1:BYTE_W] = byte_b;
                    state_d = S_START;
                end
            end
            S_START: begin
                mul_start = ena;
                if (ena) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ena && mul_done) begin
                    res_d   = mul_result;
                    state_d = S_OUT_LO;
                end else if (tmo) begin
                    res_d   = DATA_W'(FP16_QNAN);
                    state_d = S_OUT_LO;
                end
            end
            S_OUT_LO: begin
                out_valid = 1'b1;
                out_byte  = res_q[BYTE_W-1:0];
                if (ena && out_ready) state_d = S_OUT_HI;
            end
            S_OUT_HI: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_byte  = res_q[DATA_W-1:BYTE_W];
                if (ena && out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Overrun set is applied after clr so a fresh overrun wins.
        if (ena) begin
            if (clr) ovr_d = 1'b0;
            if (byte_valid && !accepting) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovr_q   <= ovr_d;
        end
    end

    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign busy        = (state_q != S_IDLE);
    assign ovr         = ovr_q;
    assign err_timeout = tmo;

endmodule

// File: tb/tb_afpm_op_sequencer.sv
// Scoreboard bench for afpm_op_sequencer with a behavioural core model.
// Optional AFPM_SEQ_TIMEOUT_EN selects the watchdog expectations.
module tb_afpm_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  byte_a = '0;
    logic [7:0]  byte_b = '0;
    logic        byte_valid = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] mul_a, mul_b;
    logic        mul_start;
    logic        mul_done = 1'b0;
    logic [15:0] mul_result = '0;
    logic [7:0]  out_byte;
    logic        out_valid, out_last;
    logic        out_ready = 1'b1;
    logic        busy, ovr, err_timeout;

    afpm_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .byte_a(byte_a), .byte_b(byte_b), .byte_valid(byte_valid),
        .clr(clr), .mul_a(mul_a), .mul_b(mul_b),
        .mul_start(mul_start), .mul_done(mul_done),
        .mul_result(mul_result), .out_byte(out_byte),
        .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .ovr(ovr),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference core: arbitrary but fixed function of the operands.
    function automatic logic [15:0] core_f(input logic [15:0] a,
                                           input logic [15:0] b);
        if (a == 16'h3E00 && b == 16'h4200) return 16'h4480;
        return a * b;
    endfunction

    logic [8:0]  exp_bytes[$];
    logic [31:0] exp_ops[$];

    // Core model: done pulse core_lat cycles after the start cycle.
    int core_lat = 3;
    bit core_never = 1'b0;
    int core_cnt = 0;
    bit core_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_busy = 1'b0;
            mul_done  = 1'b0;
        end else begin
            #2;
            mul_done = 1'b0;
            if (core_busy) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_busy  = 1'b0;
                    mul_done   = 1'b1;
                    mul_result = core_f(mul_a, mul_b);
                end
            end
            if (mul_start && !core_never) begin
                core_busy = 1'b1;
                core_cnt  = core_lat;
            end
        end
    end

    int starts = 0;
    int start_cyc = 0, lo_cyc = 0, hi_cyc = 0;
    int tmo_cnt = 0, tmo_cyc = 0;

    // Monitor: pops expectations whenever the DUT presents something.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_start) begin
                starts++;
                start_cyc = cyc;
                if (exp_ops.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got %h_%h want none",
                             mul_a, mul_b);
                end else begin
                    check("mul_ops", {mul_a, mul_b}, exp_ops.pop_front());
                end
            end
            if (err_timeout) begin
                tmo_cnt++;
                tmo_cyc = cyc;
            end
            if (out_valid && out_ready && ena) begin
                if (out_last) hi_cyc = cyc;
                else lo_cyc = cyc;
                if (exp_bytes.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h want none", out_byte);
                end else begin
                    check("out_byte", {23'd0, out_last, out_byte},
                          {23'd0, exp_bytes.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int t0 = 0;
    bit rand_ready = 1'b0;

    task automatic push_res(input logic [15:0] r);
        exp_bytes.push_back({1'b0, r[7:0]});
        exp_bytes.push_back({1'b1, r[15:8]});
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b,
                           input int gap);
        exp_ops.push_back({a, b});
        byte_valid = 1'b1;
        byte_a = a[7:0];
        byte_b = b[7:0];
        t0 = cyc;
        tick();
        byte_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            byte_a = 8'($urandom);
            byte_b = 8'($urandom);
            tick();
        end
        byte_valid = 1'b1;
        byte_a = a[15:8];
        byte_b = b[15:8];
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 300 && exp_bytes.size() != 0; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        if (exp_bytes.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d bytes pending want 0", nm,
                     exp_bytes.size());
            exp_bytes.delete();
        end
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        check(nm, 32'(out_valid), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_bytes.delete();
        exp_ops.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b;
        bit stuck;

        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_outs", {mul_a, mul_b}, 0);
        check("rst_flags",
              {24'd0, mul_start, out_valid, out_last, ovr, err_timeout, 3'd0},
              0);
        check("rst_byte", 32'(out_byte), 0);
        rst_n = 1'b1;
        tick();

        // 0001*0001 with core latency 3: latency profile.
        core_lat = 3;
        send_op(16'h0001, 16'h0001, 0);
        push_res(core_f(16'h0001, 16'h0001));
        wait_done("op1_drain");
        check("lat_start", start_cyc - t0, 2);
        check("lat_lo", lo_cyc - t0, 6);
        check("lat_hi", hi_cyc - t0, 7);
        check("op1_idle", 32'(busy), 0);
        check("op1_starts", starts, 1);

        // 3E00*4200 with result held while out_ready is low.
        out_ready = 1'b0;
        send_op(16'h3E00, 16'h4200, 0);
        push_res(16'h4480);
        wait_valid("hold_valid");
        for (int i = 0; i < 5; i++) begin
            check("hold_byte", {out_valid, out_last, out_byte}, 10'h280);
            tick();
        end
        out_ready = 1'b1;
        wait_done("hold_drain");
        check("hold_idle", 32'(busy), 0);

        // Overrun in WAIT, then clear.
        core_lat = 6;
        send_op(16'hABCD, 16'h1234, 1);
        push_res(core_f(16'hABCD, 16'h1234));
        tick();
        tick();
        byte_valid = 1'b1;
        byte_a = 8'hFF;
        tick();
        byte_valid = 1'b0;
        check("ovr_set", 32'(ovr), 1);
        wait_done("ovr_drain");
        check("ovr_sticky", 32'(ovr), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovr_clr", 32'(ovr), 0);

        // Overrun and clr in the same cycle: overrun wins.
        send_op(16'h0203, 16'h0405, 0);
        push_res(core_f(16'h0203, 16'h0405));
        clr = 1'b1;
        byte_valid = 1'b1;
        tick();
        clr = 1'b0;
        byte_valid = 1'b0;
        check("ovr_prio", 32'(ovr), 1);
        wait_done("prio_drain");
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // byte_valid in the cycle OUT_HI completes is dropped.
        core_lat = 2;
        out_ready = 1'b0;
        send_op(16'h0102, 16'h0304, 0);
        push_res(core_f(16'h0102, 16'h0304));
        wait_valid("hi_valid");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hi_last", {out_valid, out_last}, 2'b11);
        byte_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        byte_valid = 1'b0;
        check("hi_drop_ovr", 32'(ovr), 1);
        check("hi_drop_idle", 32'(busy), 0);
        tick();
        check("hi_no_new_op", 32'(busy), 0);
        check("hi_drained", exp_bytes.size(), 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // ena low in LOAD_HI: junk hi bytes ignored.
        core_lat = 3;
        exp_ops.push_back({16'h5A11, 16'h3C22});
        push_res(core_f(16'h5A11, 16'h3C22));
        byte_valid = 1'b1;
        byte_a = 8'h11;
        byte_b = 8'h22;
        tick();
        ena = 1'b0;
        byte_a = 8'hEE;
        byte_b = 8'hDD;
        tick();
        tick();
        check("ena_frozen", {28'd0, busy, mul_start, ovr, 1'b0}, 32'h8);
        ena = 1'b1;
        byte_a = 8'h5A;
        byte_b = 8'h3C;
        tick();
        byte_valid = 1'b0;
        wait_done("ena_drain");

        // Reset during WAIT.
        core_lat = 10;
        send_op(16'h7777, 16'h8888, 0);
        push_res(core_f(16'h7777, 16'h8888));
        tick();
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_wait_busy", 32'(busy), 0);
        check("rst_wait_ops", {mul_a, mul_b}, 0);
        check("rst_wait_out", {out_valid, out_last, out_byte, mul_start}, 0);
        exp_bytes.delete();
        exp_ops.delete();
        tick();
        rst_n = 1'b1;
        tick();
        core_lat = 3;
        send_op(16'h0001, 16'h0001, 0);
        push_res(16'h0001);
        wait_done("post_rst_drain");

        // Core never answers.
        core_never = 1'b1;
        tmo_cnt = 0;
        send_op(16'h1234, 16'h5678, 0);
`ifdef AFPM_SEQ_TIMEOUT_EN
        push_res(16'h7E00);
        wait_done("tmo_drain");
        check("tmo_cyc", tmo_cyc - start_cyc, 15);
        check("tmo_cnt", tmo_cnt, 1);
        check("tmo_idle", 32'(busy), 0);
`else
        stuck = 1'b1;
        for (int i = 0; i < 100; i++) begin
            stuck &= busy;
            tick();
        end
        check("no_tmo_stuck", 32'(stuck), 1);
        check("no_tmo_err", tmo_cnt, 0);
        do_reset();
`endif
        core_never = 1'b0;

        // Randomized operations.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            core_lat = $urandom_range(1, 8);
            send_op(a, b, $urandom_range(0, 3));
            push_res(core_f(a, b));
            wait_done("rand_drain");
        end
        rand_ready = 1'b0;
        check("rand_ops_left", exp_ops.size(), 0);
        check("final_ovr", 32'(ovr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
